fc_act_packer: RTL and testbench
================================

# fc_act_packer

Sequential front end for the combinational fully-connected layer datapath. It accepts a serial stream of wide post-ReLU accumulator results from the previous layer's neurons. Each result is requantized (shift, clamp) to the WIDTH-bit activation format. The results are packed into an IN-entry parallel activation vector, which is held stable for the next `layer` instance under a valid/ready handshake.

## Interface
- WIDTH, 8, activation width of the packed output entries
- IN, 128, number of entries in the output vector
- ACC_WIDTH, WIDTH*2+$clog2(85), width of each incoming accumulator result
- SHIFT, 7, right-shift applied during requantization (0 ≤ SHIFT < ACC_WIDTH-1)
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- s_valid  input  1  input beat valid
- s_ready  output  1  block can accept a beat
- s_data  input  ACC_WIDTH  accumulator result, two's complement
- s_last  input  1  final beat of a vector; may come early
- m_valid  output  1  packed vector available
- m_ready  input  1  consumer takes vector
- m_data  output  WIDTH × [0:IN-1]  packed activation vector, unpacked array
- count  output  $clog2(IN+1)  beats accepted into current vector
- err_short  output  1  sticky flag: a vector was closed by s_last with fewer than IN beats

## Operation
- Two states: FILL and HOLD.
- FILL: s_ready=1 and m_valid=0. On s_valid&&s_ready:
  - write requant(s_data) to entry `count`;
  - increment `count`.
- FILL exit: the beat that makes count==IN, or any accepted beat with s_last=1, moves the block to HOLD.
- Early close: if the closing s_last arrives with count+1<IN, set err_short. The unwritten entries stay 0.
- HOLD: s_ready=0, m_valid=1, m_data stable.
- HOLD exit: on m_valid&&m_ready, go to FILL, clear every entry to 0 and set count=0.
- Beats with count==IN cannot occur, because the block is already in HOLD. s_last on the IN-th beat is legal and does not set err_short.
- Requant steps:
  1. Negative s_data gives 0.
  2. Otherwise compute s_data>>>SHIFT.
  3. Clamp to 2^(WIDTH-1)-1, so every entry is a non-negative signed WIDTH-bit value.
- err_short clears only on reset.

## Timing
- Reset values:
  - state=FILL, count=0, every m_data entry 0;
  - m_valid=0, err_short=0;
  - s_ready=1 once rst_n is high.
- s_ready and m_valid are decoded directly from the state register; they have no combinational path from s_valid or m_ready.
- Latency: the closing beat is accepted at edge N, and m_valid=1 from edge N on.
- Throughput: one beat per cycle in FILL. Minimum vector period is IN+1 cycles: IN fill cycles plus at least one HOLD cycle.
- There is no HOLD→FILL bypass: the cycle of the m_ready handshake shows s_ready=0, and the next cycle shows s_ready=1.
- Reset mid-vector: the partial contents are discarded and all outputs return to their reset values asynchronously.

## Configuration
- FC_PACK_ROUND_EN defined: round half-up before the shift, i.e. (s_data + 2^(SHIFT-1))>>>SHIFT, computed in ACC_WIDTH+1 bits and then clamped. With SHIFT=0 no rounding term is added.
- FC_PACK_ROUND_EN undefined: pure truncation.

## Structure
- Package fc_pkg holds:
  - default WIDTH, IN, ACC_WIDTH, SHIFT;
  - a state enum typedef {FILL, HOLD};
  - a typedef for the activation vector.
- One sub-module, fc_requant: purely combinational shift/round/clamp, parameterized by ACC_WIDTH, WIDTH and SHIFT. The packer instantiates it once on s_data.

## Test plan
1. Full vector, truncation, with s_data[i]=i<<7 for i=0..127 and m_ready=0: m_valid=1 the edge after beat 127. m_data[i]=min(i,127), err_short=0, s_ready=0 until the handshake.
2. Clamp and negatives: s_data=1<<20 gives 127. s_data=-5 (two's complement) gives 0. s_data=127<<7 gives 127. s_data=128<<7 gives 127.
3. Rounding: s_data=200 gives 1 without FC_PACK_ROUND_EN and 2 with it. s_data=63 gives 0 in both builds.
4. Early s_last on beat 10: m_valid=1, entries 10..127 are 0, err_short=1. err_short stays 1 through the next full vector.
5. Backpressure and refill: hold m_ready=0 for 20 cycles with s_valid=1. m_data stays stable and no beat is accepted. After the handshake the next vector is filled starting at entry 0, with no stale entries left from the previous vector.
6. Assert rst_n=0 at count=50: count=0, m_valid=0, all entries 0, err_short=0 immediately. After release, a full vector packs correctly.

Source files
------------

// File: rtl/fc_pkg.sv
// Shared types and default sizing for the fully-connected activation packer.
// Build option: FC_PACK_ROUND_EN selects round-half-up requantization.
package fc_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_IN    = 128;
  localparam int DEF_ACC_W = DEF_WIDTH * 2 + $clog2(85);
  localparam int DEF_SHIFT = 7;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } pack_state_t;

  typedef logic [DEF_WIDTH-1:0] act_vec_t [0:DEF_IN-1];

endpackage

// File: rtl/fc_requant.sv
// Combinational requantizer: drop negatives, shift, clamp to positive range.
// Build option: FC_PACK_ROUND_EN adds a half-LSB term before the shift.
module fc_requant #(
  parameter int ACC_WIDTH = 23,
  parameter int WIDTH     = 8,
  parameter int SHIFT     = 7
) (
  input  logic [ACC_WIDTH-1:0] acc,
  output logic [WIDTH-1:0]     act
);

  localparam logic signed [ACC_WIDTH:0] MAXV =
    (ACC_WIDTH+1)'((1 << (WIDTH-1)) - 1);

  logic signed [ACC_WIDTH:0] ext;
  logic signed [ACC_WIDTH:0] sum;
  logic signed [ACC_WIDTH:0] shd;

  assign ext = {acc[ACC_WIDTH-1], acc};

`ifdef FC_PACK_ROUND_EN
  localparam int RS = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [ACC_WIDTH:0] RND =
    (SHIFT > 0) ? ((ACC_WIDTH+1)'(1) << RS) : '0;
  // One extra bit keeps the rounded maximum positive value from wrapping.
  assign sum = ext + RND;
`else
  assign sum = ext;
`endif

  assign shd = sum >>> SHIFT;

  always_comb begin
    act = WIDTH'(shd);
    unique case (1'b1)
      acc[ACC_WIDTH-1]: act = '0;
      (shd > MAXV):     act = WIDTH'(MAXV);
      default:          act = WIDTH'(shd);
    endcase
  end

endmodule

// File: rtl/fc_act_packer.sv
// Packs a serial stream of requantized accumulator results into a held vector.
// Build option: FC_PACK_ROUND_EN enables rounding in fc_requant.
module fc_act_packer
  import fc_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int IN        = DEF_IN,
  parameter int ACC_WIDTH = WIDTH * 2 + $clog2(85),
  parameter int SHIFT     = DEF_SHIFT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [ACC_WIDTH-1:0]     s_data,
  input  logic                     s_last,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [WIDTH-1:0]         m_data [0:IN-1],
  output logic [$clog2(IN+1)-1:0]  count,
  output logic                     err_short
);

  localparam int CW = $clog2(IN + 1);
  localparam int IW = (IN > 1) ? $clog2(IN) : 1;

  pack_state_t      state;
  pack_state_t      nxt;
  logic [WIDTH-1:0] act;
  logic [IW-1:0]    idx;
  logic             acc;
  logic             last_full;
  logic             take;

  fc_requant #(
    .ACC_WIDTH(ACC_WIDTH),
    .WIDTH    (WIDTH),
    .SHIFT    (SHIFT)
  ) u_rq (
    .acc(s_data),
    .act(act)
  );

  assign idx       = count[IW-1:0];
  assign acc       = s_valid && s_ready;
  assign take      = m_valid && m_ready;
  assign last_full = (count == CW'(IN - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FILL;
    else        state <= nxt;
  end

  always_comb begin
    nxt     = state;
    s_ready = 1'b0;
    m_valid = 1'b0;
    unique case (state)
      FILL: begin
        s_ready = 1'b1;
        if (acc && (s_last || last_full)) nxt = HOLD;
      end
      HOLD: begin
        m_valid = 1'b1;
        if (m_ready) nxt = FILL;
      end
      default: nxt = FILL;
    endcase
  end

  // Entries are cleared on release so a short next vector leaves zeros.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= '0;
      err_short <= 1'b0;
      for (int i = 0; i < IN; i++) m_data[i] <= '0;
    end else if (take) begin
      count <= '0;
      for (int i = 0; i < IN; i++) m_data[i] <= '0;
    end else if (acc) begin
      m_data[idx] <= act;
      count       <= count + CW'(1);
      if (s_last && !last_full) err_short <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fc_act_packer.sv
// Directed self-checking bench for fc_act_packer.
// Build option: FC_PACK_ROUND_EN switches rounding expectations.
module tb_fc_act_packer;

  localparam int WIDTH = 8;
  localparam int IN    = 128;
  localparam int AW    = 23;
  localparam int CW    = 8;

  logic             clk;
  logic             rst_n;
  logic             s_valid;
  logic             s_ready;
  logic [AW-1:0]    s_data;
  logic             s_last;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data [0:IN-1];
  logic [CW-1:0]    count;
  logic             err_short;

  int checks = 0;
  int errors = 0;
  int exp_v [0:IN-1];

  typedef struct {
    string name;
    int    din;
    int    exp_t;
    int    exp_r;
  } vec_t;

  vec_t tbl [0:11];

  fc_act_packer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .s_last   (s_last),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .count    (count),
    .err_short(err_short)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_vec(input string nm);
    int bad;
    bad = 0;
    for (int i = 0; i < IN; i++)
      if (int'(m_data[i]) != exp_v[i]) bad++;
    chk(nm, bad, 0);
  endtask

  task automatic clr_exp();
    for (int i = 0; i < IN; i++) exp_v[i] = 0;
  endtask

  task automatic beat(input int d, input logic l);
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = AW'(d);
    s_last  = l;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic handshake();
    @(negedge clk);
    m_ready = 1'b1;
    chk("hs_sready_low", int'(s_ready), 0);
    @(posedge clk);
    #1;
    m_ready = 1'b0;
    chk("hs_sready_high", int'(s_ready), 1);
    chk("hs_mvalid_low", int'(m_valid), 0);
    chk("hs_count_zero", int'(count), 0);
  endtask

  initial begin
    tbl[0]  = '{"zero",      0,           0,   0};
    tbl[1]  = '{"big",       1 << 20,     127, 127};
    tbl[2]  = '{"neg5",      -5,          0,   0};
    tbl[3]  = '{"127sh",     127 << 7,    127, 127};
    tbl[4]  = '{"128sh",     128 << 7,    127, 127};
    tbl[5]  = '{"r200",      200,         1,   2};
    tbl[6]  = '{"r63",       63,          0,   0};
    tbl[7]  = '{"r64",       64,          0,   1};
    tbl[8]  = '{"five",      5 << 7,      5,   5};
    tbl[9]  = '{"maxpos",    32'h3FFFFF,  127, 127};
    tbl[10] = '{"neg1",      -1,          0,   0};
    tbl[11] = '{"r383",      383,         2,   3};

    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;
    m_ready = 1'b0;
    #1;
    clr_exp();
    chk("rst_count", int'(count), 0);
    chk("rst_mvalid", int'(m_valid), 0);
    chk("rst_err", int'(err_short), 0);
    chk_vec("rst_entries");
    #12;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_sready", int'(s_ready), 1);

    // full vector, truncation
    for (int i = 0; i < IN; i++) begin
      beat(i << 7, 1'b0);
      exp_v[i] = i;
      if (i == IN - 2) begin
        chk("t1_mvalid_pre", int'(m_valid), 0);
        chk("t1_count_pre", int'(count), IN - 1);
      end
    end
    chk("t1_mvalid", int'(m_valid), 1);
    chk("t1_sready", int'(s_ready), 0);
    chk("t1_count", int'(count), IN);
    chk("t1_err", int'(err_short), 0);
    chk_vec("t1_entries");

    // backpressure with s_valid held high
    begin
      int moved;
      moved = 0;
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = AW'(99 << 7);
      for (int c = 0; c < 20; c++) begin
        @(posedge clk);
        #1;
        if (count != CW'(IN) || !m_valid || s_ready) moved++;
        for (int i = 0; i < IN; i++)
          if (int'(m_data[i]) != exp_v[i]) moved++;
      end
      chk("t5_stall", moved, 0);
      handshake();
      s_valid = 1'b0;
      clr_exp();
      chk_vec("t5_cleared");
    end
    for (int i = 0; i < IN; i++) begin
      beat((127 - i) << 7, 1'b0);
      exp_v[i] = 127 - i;
    end
    chk("t5_count", int'(count), IN);
    chk("t5_err", int'(err_short), 0);
    chk_vec("t5_refill");
    handshake();

    // early s_last on the tenth beat
    clr_exp();
    for (int i = 0; i < 10; i++) begin
      beat((i + 1) << 7, i == 9);
      exp_v[i] = i + 1;
    end
    chk("t4_mvalid", int'(m_valid), 1);
    chk("t4_count", int'(count), 10);
    chk("t4_err", int'(err_short), 1);
    chk_vec("t4_entries");
    handshake();
    clr_exp();
    for (int i = 0; i < IN; i++) begin
      beat(i << 7, 1'b0);
      exp_v[i] = i;
    end
    chk("t4_err_sticky", int'(err_short), 1);
    chk_vec("t4_full");
    handshake();

    // requant table, one-beat vectors
    for (int k = 0; k < 12; k++) begin
      int e;
`ifdef FC_PACK_ROUND_EN
      e = tbl[k].exp_r;
`else
      e = tbl[k].exp_t;
`endif
      beat(tbl[k].din, 1'b1);
      chk({"rq_", tbl[k].name}, int'(m_data[0]), e);
      chk({"rq_mv_", tbl[k].name}, int'(m_valid), 1);
      handshake();
    end

    // reset mid-vector
    for (int i = 0; i < 50; i++) beat(i << 7, 1'b0);
    chk("t6_count_pre", int'(count), 50);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    clr_exp();
    chk("t6_count", int'(count), 0);
    chk("t6_mvalid", int'(m_valid), 0);
    chk("t6_err", int'(err_short), 0);
    chk_vec("t6_entries");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < IN; i++) begin
      beat((i + 1) << 7, i == IN - 1);
      exp_v[i] = (i + 1 > 127) ? 127 : i + 1;
    end
    chk("t6_mvalid_post", int'(m_valid), 1);
    chk("t6_err_last", int'(err_short), 0);
    chk_vec("t6_full");
    handshake();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
